// File: rtl/rom_mac_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rom_mac_ram                                              |
// | Description : Sequenced ROM-operand multiplier that stores or          |
// |               accumulates the product into an internal RAM word and    |
// |               reads the written word back.                             |
// |               Optional macro ROM_MAC_SAT_EN: saturate the stored word  |
// |               to all-ones on accumulate overflow (default: wrap).      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rom_mac_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     adr1,
  input  logic [ADDR_W-1:0]     adr2,
  input  logic [ADDR_W-1:0]     adr_ram,
  output logic [2*DATA_W-1:0]   product,
  output logic [2*DATA_W-1:0]   result,
  output logic [3:0]            st_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int c_pw    = 2 * DATA_W;
  localparam int c_depth = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD1  = 4'd1,
    S_RD2  = 4'd2,
    S_MUL  = 4'd3,
    S_WR   = 4'd4,
    S_RDBK = 4'd5,
    S_DONE = 4'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  // Registered copy of the sequencer state; st_out/busy/done are decoded
  // from it, so done appears on the edge after the sequencer leaves DONE's
  // entry and the next request can only be taken once IDLE is reached.
  logic [3:0]          r_st_q;

  logic [ADDR_W-1:0]   r_adr1;
  logic [ADDR_W-1:0]   r_adr2;
  logic [ADDR_W-1:0]   r_adr_ram;
  logic                r_mode;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [c_pw-1:0]     r_product;
  logic [c_pw-1:0]     r_result;
  logic                r_ovf;
  logic [c_pw-1:0]     r_ram [c_depth];

  logic [c_pw-1:0]     w_mul;
  logic [c_pw-1:0]     w_ram_rd;
  logic [c_pw:0]       w_sum;
  logic                w_carry;
  logic [c_pw-1:0]     w_wr_data;

  // Constant ROM contents: word i holds i+1, wrapping at the operand width.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + DATA_W'(1);
  endfunction

  // Sequencer state register plus the one-cycle-delayed status copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_st_q  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_st_q  <= r_state;
    end
  end

  // Next-state logic: fixed walk through the operation, start only in IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_RD1 : S_IDLE;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_MUL;
      S_MUL:   w_next = S_WR;
      S_WR:    w_next = S_RDBK;
      S_RDBK:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write-data selection: plain store, or accumulate with wrap/saturate.
  always_comb begin
    w_mul     = {{DATA_W{1'b0}}, r_op_a} * {{DATA_W{1'b0}}, r_op_b};
    w_ram_rd  = r_ram[r_adr_ram];
    w_sum     = {1'b0, w_ram_rd} + {1'b0, r_product};
    w_carry   = w_sum[c_pw];
    w_wr_data = w_sum[c_pw-1:0];
    if (!r_mode) begin
      w_wr_data = r_product;
`ifdef ROM_MAC_SAT_EN
    end else if (w_carry) begin
      w_wr_data = '1;
`endif
    end
  end

  // Datapath: request capture, operand fetch, multiply, RAM write, readback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr1    <= '0;
      r_adr2    <= '0;
      r_adr_ram <= '0;
      r_mode    <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_product <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < c_depth; i++) begin
        r_ram[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_adr1    <= adr1;
            r_adr2    <= adr2;
            r_adr_ram <= adr_ram;
            r_mode    <= mode;
          end
        end
        S_RD1:  r_op_a    <= rom_word(r_adr1);
        S_RD2:  r_op_b    <= rom_word(r_adr2);
        S_MUL:  r_product <= w_mul;
        S_WR: begin
          r_ram[r_adr_ram] <= w_wr_data;
          r_ovf            <= r_mode & w_carry;
        end
        S_RDBK: r_result  <= w_ram_rd;
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign result  = r_result;
  assign ovf     = r_ovf;
  assign st_out  = r_st_q;
  assign busy    = (r_st_q != 4'd0);
  assign done    = (r_st_q == 4'd6);

endmodule
`default_nettype wire

// File: tb/tb_rom_mac_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_rom_mac_ram                                           |
// | Description : Self-checking bench for rom_mac_ram: directed scenarios  |
// |               followed by random operations against an array model.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_rom_mac_ram;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int PW    = 2 * DW;
  localparam int DEPTH = 1 << AW;
`ifdef ROM_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] adr1;
  logic [AW-1:0] adr2;
  logic [AW-1:0] adr_ram;
  logic [PW-1:0] product;
  logic [PW-1:0] result;
  logic [3:0]    st_out;
  logic          busy;
  logic          done;
  logic          ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int model_ram [DEPTH];
  int exp_prod;
  int exp_res;
  int exp_ovf;

  always #5 clk = ~clk;

  rom_mac_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .adr1    (adr1),
    .adr2    (adr2),
    .adr_ram (adr_ram),
    .product (product),
    .result  (result),
    .st_out  (st_out),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rom_val(input int i);
    return (i + 1) % (1 << DW);
  endfunction

  // Reference: product of ROM words, store or add, wrap/saturate at PW bits.
  task automatic model_op(input int a1, input int a2, input int ar, input int m);
    int s;
    exp_prod = rom_val(a1) * rom_val(a2);
    if (m == 0) begin
      model_ram[ar] = exp_prod;
      exp_ovf = 0;
    end else begin
      s = model_ram[ar] + exp_prod;
      exp_ovf = (s >= (1 << PW)) ? 1 : 0;
      if (exp_ovf == 1) model_ram[ar] = SAT_EN ? (1 << PW) - 1 : s - (1 << PW);
      else              model_ram[ar] = s;
    end
    exp_res = model_ram[ar];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_ram[i] = 0;
  endtask

  task automatic scramble();
    adr1    = AW'($urandom);
    adr2    = AW'($urandom);
    adr_ram = AW'($urandom);
    mode    = 1'($urandom);
  endtask

  // Present a request for the next rising edge, then withdraw and scramble it.
  task automatic issue(input int a1, input int a2, input int ar, input int m);
    @(negedge clk);
    adr1    = AW'(a1);
    adr2    = AW'(a2);
    adr_ram = AW'(ar);
    mode    = 1'(m);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_st"},   32'(st_out),  32'd0);
    chk({tag, "_busy"}, 32'(busy),    32'd0);
    chk({tag, "_done"}, 32'(done),    32'd0);
    chk({tag, "_ovf"},  32'(ovf),     32'd0);
    chk({tag, "_prod"}, 32'(product), 32'd0);
    chk({tag, "_res"},  32'(result),  32'd0);
  endtask

  // One full operation with per-cycle status checks; optional second start
  // pulse while the sequencer is in RD2 must be ignored.
  task automatic run_op(input int a1, input int a2, input int ar, input int m, input bit glitch);
    issue(a1, a2, ar, m);
    model_op(a1, a2, ar, m);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk("st_out", 32'(st_out), (k <= 6) ? 32'(k) : 32'd0);
      chk("busy",   32'(busy),   (k <= 6) ? 32'd1 : 32'd0);
      chk("done",   32'(done),   (k == 6) ? 32'd1 : 32'd0);
      if (k >= 6) begin
        chk("product", 32'(product), 32'(exp_prod));
        chk("result",  32'(result),  32'(exp_res));
        chk("ovf",     32'(ovf),     32'(exp_ovf));
      end
      if (glitch && k == 1) begin
        scramble();
        start = 1'b1;
      end
      if (glitch && k == 2) start = 1'b0;
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    adr1    = '0;
    adr2    = '0;
    adr_ram = '0;
    model_clear();

    // Reset state, released just after a rising edge so the first request
    // lands on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;

    run_op(1, 2, 5, 0, 1'b0);
    chk("d1_prod", 32'(product), 32'd6);
    chk("d1_res",  32'(result),  32'd6);
    run_op(2, 5, 7, 0, 1'b0);
    chk("d2_res",  32'(result),  32'd18);
    run_op(4, 6, 1, 0, 1'b0);
    chk("d3_res",  32'(result),  32'd35);
    // RAM[5] untouched by the other stores: 6 + 1*1.
    run_op(0, 0, 5, 1, 1'b0);
    chk("ram5_acc", 32'(result), 32'd7);

    // Accumulation chain of 8*8 into RAM[0].
    for (int i = 1; i <= 4; i++) begin
      run_op(7, 7, 0, 1, 1'b0);
      chk("acc_res", 32'(result), (i < 4) ? 32'(64 * i) : (SAT_EN ? 32'd255 : 32'd0));
      chk("acc_ovf", 32'(ovf),    (i == 4) ? 32'd1 : 32'd0);
    end
    run_op(3, 3, 2, 0, 1'b0);
    chk("store_clears_ovf", 32'(ovf), 32'd0);

    // Second start during the operation is dropped.
    run_op(1, 1, 6, 0, 1'b1);
    chk("glitch_res", 32'(result), 32'd4);

    // Reset while the accumulate into RAM[3] is in its write cycle.
    run_op(2, 3, 3, 0, 1'b0);
    chk("pre_rst_res", 32'(result), 32'd12);
    issue(0, 0, 3, 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    check_zero("held_rst");
    #1;
    rst = 1'b1;
    model_clear();
    run_op(1, 1, 3, 1, 1'b0);
    chk("post_rst_acc", 32'(result), 32'd4);

    // Random operations against the model.
    repeat (24) begin
      int a1, a2, ar, m;
      bit g;
      a1 = int'($urandom_range(0, DEPTH - 1));
      a2 = int'($urandom_range(0, DEPTH - 1));
      ar = int'($urandom_range(0, DEPTH - 1));
      m  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      g  = 1'($urandom);
      run_op(a1, a2, ar, m, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_mac_ram.md
ROM_MAC_RAM -- requirements
Module: rom_mac_ram

Interface
REQ-001 Parameter DATA_W, default 4, ROM operand width in bits.
REQ-002 Parameter ADDR_W, default 3, ROM and RAM address width; depth = 2^ADDR_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 mode  input  1  0 = multiply-store, 1 = multiply-accumulate into RAM word.
REQ-007 adr1, adr2  input  ADDR_W each  ROM addresses of operands A and B.
REQ-008 adr_ram  input  ADDR_W  RAM destination address.
REQ-009 product  output  2*DATA_W  registered A*B of the current operation.
REQ-010 result  output  2*DATA_W  registered RAM readback after the write.
REQ-011 st_out  output  4  current FSM state encoding.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse in DONE.
REQ-014 ovf  output  1  registered overflow flag of the last accumulate.

Function
REQ-015 ROM SHALL be constant: ROM[i] = (i+1) mod 2^DATA_W.
REQ-016 RAM SHALL hold 2^ADDR_W words of 2*DATA_W bits, internal, one write per operation.
REQ-017 FSM states and st_out codes: IDLE=0, RD1=1, RD2=2, MUL=3, WR=4, RDBK=5, DONE=6; codes 7-15 unused and SHALL go to IDLE.
REQ-018 IDLE with start=1 SHALL capture adr1, adr2, adr_ram, mode into internal registers and go to RD1; later input changes SHALL not affect the operation.
REQ-019 RD1 loads op A = ROM[adr1]; RD2 loads op B = ROM[adr2]; MUL loads product = A*B, full 2*DATA_W width, never overflows.
REQ-020 WR with mode=0 SHALL write product to RAM[adr_ram] and clear ovf.
REQ-021 WR with mode=1 SHALL compute RAM[adr_ram]+product at 2*DATA_W+1 bits; carry out sets ovf, else ovf cleared; stored value per REQ-031/032.
REQ-022 RDBK SHALL load result = RAM[adr_ram] (post-write value).
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-024 Latency: start sampled at edge N -> done high between edges N+6 and N+7; a back-to-back start is accepted at edge N+7 at the earliest.
REQ-025 start while busy=1 SHALL be ignored, not queued.
REQ-026 product, result, ovf SHALL hold their values until overwritten by the next operation.
REQ-027 adr1 = adr2 is legal (squaring); same adr_ram across operations is legal (accumulation chain).

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, st_out=0, busy=0, done=0, ovf=0, product=0, result=0, all RAM words=0, operand registers=0.
REQ-029 Reset asserted mid-operation SHALL abort with no RAM write completing after the reset edge; release resumes in IDLE.
REQ-030 First start SHALL be honoured at the first rising edge after rst deasserts.

Configuration
REQ-031 Macro ROM_MAC_SAT_EN defined: on accumulate overflow the stored word and result SHALL be all-ones (2^(2*DATA_W)-1); ovf=1.
REQ-032 Macro ROM_MAC_SAT_EN undefined: on overflow the stored word SHALL be the low 2*DATA_W bits of the sum (wrap); ovf=1.

Verification (defaults DATA_W=4, ADDR_W=3)
REQ-033 Reset, then start adr1=1, adr2=2, adr_ram=5, mode=0 -> product=6, result=6, done pulse 6 cycles after start, st_out walks 1..6 then 0.
REQ-034 start adr1=2, adr2=5, adr_ram=7, mode=0 -> product=18, result=18; then adr1=4, adr2=6, adr_ram=1 -> product=35, result=35; RAM[5] still 6.
REQ-035 Four starts adr1=7, adr2=7, adr_ram=0, mode=1 -> result 64,128,192 with ovf=0, fourth: wrap build result=0 ovf=1, ROM_MAC_SAT_EN build result=255 ovf=1.
REQ-036 start pulsed again at RD2 with different addresses -> ignored; only one done pulse, result from first request.
REQ-037 rst=0 during WR of adr_ram=3 after a prior store of 12 there -> all outputs 0 immediately, RAM[3]=0 after release, next op works normally.
